// File: rtl/scope_capture_pkg.sv
// rtl/scope_capture_pkg.sv - shared states, mode codes and default widths for the scope capture path
package scope_capture_pkg;

  localparam int SAMPLE_W_DEF = 12;
  localparam int DEPTH_DEF    = 32;
  localparam int PRETRIG_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_HOLD  = 3'd4
  } cap_state_t;

  localparam logic [1:0] MODE_FREE   = 2'b00;
  localparam logic [1:0] MODE_NORMAL = 2'b01;
  localparam logic [1:0] MODE_SINGLE = 2'b10;

  // The unused code 11 behaves exactly like normal mode.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_NORMAL : m;
  endfunction

endpackage

// File: rtl/level_crossing_det.sv
// rtl/level_crossing_det.sv - remembers the previous accepted sample and flags a rising threshold crossing
module level_crossing_det #(
  parameter int SAMPLE_W = 12
) (
  input  logic                dff_clock,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic                freeze,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] trig_level,
  output logic                cross_hit
);

  logic [SAMPLE_W-1:0] prev_sample;
  logic                prev_valid;

  // History advances in every state; only freeze and reset stop it.
  always_ff @(posedge dff_clock or posedge reset) begin
    if (reset) begin
      prev_sample <= '0;
      prev_valid  <= 1'b0;
    end else if (sample_valid && !freeze) begin
      prev_sample <= sample;
      prev_valid  <= 1'b1;
    end
  end

  assign cross_hit = prev_valid && (prev_sample < trig_level) && (sample >= trig_level);

endmodule

// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - steers mic samples into a ring of slot registers and freezes trigger-aligned frames
module capture_sequencer
  import scope_capture_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int PRETRIG  = PRETRIG_DEF
) (
  input  logic                     dff_clock,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic [SAMPLE_W-1:0]      sample,
  input  logic [SAMPLE_W-1:0]      trig_level,
  input  logic [1:0]               mode,
  input  logic                     arm,
  input  logic                     freeze,
  output logic [DEPTH-1:0]         slot_en,
  output logic [SAMPLE_W-1:0]      slot_d,
  output logic [$clog2(DEPTH)-1:0] start_ptr,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int POST_LEN = DEPTH - PRETRIG;

  cap_state_t       state, state_d;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_d;
  logic [PTR_W-1:0] cnt, cnt_d;
  logic [PTR_W-1:0] start_ptr_d;
  logic [1:0]       run_mode, run_mode_d;
  logic             write_en;
  logic             last_write;
  logic             cross_hit;
  logic [DEPTH-1:0] slot_dec;

  level_crossing_det #(
    .SAMPLE_W (SAMPLE_W)
  ) u_cross (
    .dff_clock    (dff_clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .freeze       (freeze),
    .sample       (sample),
    .trig_level   (trig_level),
    .cross_hit    (cross_hit)
  );

  always_ff @(posedge dff_clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      cnt       <= '0;
      start_ptr <= '0;
      run_mode  <= MODE_FREE;
    end else begin
      state     <= state_d;
      wr_ptr    <= wr_ptr_d;
      cnt       <= cnt_d;
      start_ptr <= start_ptr_d;
      run_mode  <= run_mode_d;
    end
  end

  // Mode is sampled only when leaving IDLE/HOLD so a frame in flight never changes rules.
  always_comb begin
    state_d     = state;
    wr_ptr_d    = wr_ptr;
    cnt_d       = cnt;
    start_ptr_d = start_ptr;
    run_mode_d  = run_mode;
    write_en    = 1'b0;
    last_write  = 1'b0;
    if (!freeze) begin
      write_en = sample_valid &&
                 (state == ST_FILL || state == ST_ARMED || state == ST_POST);
      if (write_en) begin
        wr_ptr_d = wr_ptr + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (norm_mode(mode) != MODE_SINGLE || arm) begin
            state_d    = ST_FILL;
            run_mode_d = norm_mode(mode);
            cnt_d      = '0;
          end
        end
        ST_FILL: begin
          if (write_en) begin
            if (cnt == PTR_W'(PRETRIG - 1)) begin
              state_d = ST_ARMED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt + 1'b1;
            end
          end
        end
        ST_ARMED: begin
          if (write_en && (run_mode == MODE_FREE || cross_hit)) begin
            start_ptr_d = wr_ptr - PTR_W'(PRETRIG);
            if (POST_LEN == 1) begin
              state_d    = ST_HOLD;
              last_write = 1'b1;
              cnt_d      = '0;
            end else begin
              state_d = ST_POST;
              cnt_d   = PTR_W'(1);
            end
          end
        end
        ST_POST: begin
          if (write_en) begin
            if (cnt == PTR_W'(POST_LEN - 1)) begin
              state_d    = ST_HOLD;
              last_write = 1'b1;
              cnt_d      = '0;
            end else begin
              cnt_d = cnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (norm_mode(mode) != MODE_SINGLE || arm) begin
            state_d    = ST_FILL;
            run_mode_d = norm_mode(mode);
            cnt_d      = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    slot_dec         = '0;
    slot_dec[wr_ptr] = 1'b1;
  end

  // Bank strobes are registered so the write lands one cycle after the sample strobe.
  always_ff @(posedge dff_clock or posedge reset) begin
    if (reset) begin
      slot_en    <= '0;
      slot_d     <= '0;
      frame_done <= 1'b0;
    end else begin
      slot_en    <= write_en ? slot_dec : '0;
      frame_done <= last_write;
      if (write_en) begin
        slot_d <= sample;
      end
    end
  end

  assign busy = (state == ST_FILL) || (state == ST_ARMED) || (state == ST_POST);

endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Sequences the load-enables of the waveform sample register bank in the voice scope. Each microphone sample strobe is steered into exactly one enabled D register (a one-hot `slot_en`), with the bank treated as a ring buffer. A trigger FSM (free-run, normal or single-shot mode, with pre-trigger depth) freezes a trigger-aligned frame for the OLED display. The block sits between the mic sampler and the register bank; the display reads the bank starting at `start_ptr`.

## Interface
- `SAMPLE_W`, 12: sample width; unsigned.
- `DEPTH`, 32: number of slot registers; must be a power of 2, ≥4.
- `PRETRIG`, 8: samples kept before the trigger; 1 ≤ PRETRIG < DEPTH.
- `dff_clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `sample_valid` in 1: one-cycle strobe per new mic sample.
- `sample` in SAMPLE_W: mic sample; qualified by `sample_valid`.
- `trig_level` in SAMPLE_W: trigger threshold; unsigned.
- `mode` in 2: 00 free-run; 01 normal; 10 single-shot; 11 treated as 01.
- `arm` in 1: one-cycle pulse; used in single-shot mode only.
- `freeze` in 1: level input (switch); suspends capture.
- `slot_en` out DEPTH: one-hot write enable for the register bank, or all zero.
- `slot_d` out SAMPLE_W: data for the enabled slot.
- `start_ptr` out log2(DEPTH): index of the oldest sample of the held frame.
- `frame_done` out 1: one-cycle pulse on the last write of a frame.
- `busy` out 1: high in FILL, ARMED or POST.

## Operation
- States: IDLE, FILL, ARMED, POST, HOLD.
- Reset: state IDLE; `wr_ptr`=0; `start_ptr`=0; `slot_en`=0; `slot_d`=0; `frame_done`=0; `busy`=0; `prev_valid`=0.
- IDLE→FILL when mode≠10, or when `arm`=1.
- A write occurs on `sample_valid` only in FILL, ARMED or POST, and only when `freeze`=0. Each write:
  - enables slot `wr_ptr`;
  - sets `wr_ptr` = `wr_ptr`+1 mod DEPTH (natural wrap).
- FILL: counts PRETRIG writes, then moves to ARMED.
- ARMED: evaluates the trigger condition on each write.
  - Mode 00: condition is always true.
  - Otherwise: rising crossing, i.e. `prev_valid` && `prev_sample` < `trig_level` && `sample` ≥ `trig_level`.
  - On trigger: the triggering sample is written as the first POST sample; `start_ptr` latches (trigger slot − PRETRIG) mod DEPTH; go to POST.
- POST: performs DEPTH−PRETRIG writes in total, including the trigger sample, then goes to HOLD. `frame_done` pulses with the final `slot_en`.
- HOLD: no writes.
  - Mode 10: `arm`→FILL.
  - Mode 00/01: →FILL on the next cycle with `freeze`=0.
- `prev_sample`/`prev_valid` update on every `sample_valid` with `freeze`=0, in any state. They are cleared only by reset.
- `freeze`=1:
  - state, counters, `wr_ptr` and `prev_sample` hold;
  - `slot_en` is forced to 0;
  - no trigger is evaluated.
- `arm` outside IDLE/HOLD, or in modes 00/01, is ignored.
- A `mode` change takes effect only at the IDLE or HOLD exit decision. It never aborts a frame in progress.

## Timing
- `slot_en` and `slot_d` are registered: asserted exactly one cycle after the qualifying `sample_valid`, for one cycle.
- `frame_done` is coincident with the last `slot_en`. The state reads HOLD in that same cycle.
- `start_ptr` updates in the cycle after the trigger strobe. It is stable throughout POST and HOLD.
- Simultaneous `arm` and `sample_valid` in HOLD: the transition to FILL occurs and that sample is NOT written.
- `sample_valid` strobes never arrive on consecutive cycles (≥2-cycle spacing). Behaviour under back-to-back strobes is still defined: every strobe is processed.
- Reset asserted mid-frame: all outputs clear immediately (asynchronous); a partial frame is discarded.

## Structure
- Shared package `scope_capture_pkg`:
  - state encodings (IDLE..HOLD);
  - mode codes (MODE_FREE, MODE_NORMAL, MODE_SINGLE);
  - default widths.
- Sub-module `level_crossing_det`: holds `prev_sample`/`prev_valid` and outputs a registered-compare `cross` flag, combinational in the strobe cycle.
- Remaining logic: FSM, write/post counters, ring pointer, one-hot decoder.

## Test plan
- Reset, mode 00, 40 strobes with ramp data 0..39:
  - first `slot_en` = bit 0 with `slot_d`=0;
  - `frame_done` on the 32nd write (sample 31);
  - `start_ptr` = 0 (trigger at slot 8);
  - the next frame starts immediately.
- Mode 01, `trig_level`=2048:
  - samples 1000 ×20, then 3000 at write index 20;
  - trigger at slot 20; `start_ptr`=12;
  - `frame_done` after 24 writes total post-trigger, including the trigger sample.
- Mode 01 with a constant 3000 input: never triggers (no rising crossing); `busy` stays 1; `frame_done` never asserts.
- Mode 10: frame completes, then 50 strobes produce no `slot_en`; an `arm` pulse coincident with a strobe writes nothing that cycle; the next strobe writes.
- `freeze` raised mid-POST for 10 strobes: zero writes; on release the remaining POST writes complete and `start_ptr` is unchanged.
- `reset` pulsed mid-POST: `slot_en`, `busy` and `start_ptr` clear immediately; after release, mode 01 requires 8 FILL writes before any trigger.
